rr_capture_buffer: RTL and testbench

Parametrised successor to the two-source alternating read/write register. Captures one word per write cycle from one of NSRC write sources, chosen by a round-robin pointer or a fixed selection. Stores the words in a DEPTH-entry circular buffer and returns them oldest-first through a registered read port that tags each word with its source index. Sits between multiple producer datapaths and a single consumer that drains with a read strobe.

---
 rtl/rr_capture_buffer_pkg.sv | 34 +++
 rtl/rr_capture_buffer_if.sv | 43 ++++
 rtl/rr_capture_buffer_mod_counter.sv | 33 +++
 rtl/rr_capture_buffer.sv | 144 ++++++++++++++
 tb/tb_rr_capture_buffer.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/rr_capture_buffer_pkg.sv
// ---------------------------------------------------------------------------
// rr_capture_buffer_pkg
// Shared definitions for the round-robin capture buffer:
//   - clog2()                 : width helper, never returns less than 1
//   - RR_CAPTURE_BUFFER_SLICE : picks word idx out of a flattened bus
//   - RESET_*                 : reset values of the single-bit status flops
// No ports (package).
// ---------------------------------------------------------------------------
`ifndef RR_CAPTURE_BUFFER_SLICE
`define RR_CAPTURE_BUFFER_SLICE(vec, idx, width) vec[(idx)*(width) +: (width)]
`endif

package rr_capture_buffer_pkg;

    // Minimum result is 1 so that a one-value field still gets a real bit.
    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result    = result + 1;
            remaining = remaining >> 1;
        end
        if (result < 1) begin
            result = 1;
        end
        return result;
    endfunction

    localparam logic RESET_RD_VALID = 1'b0;
    localparam logic RESET_OVERFLOW = 1'b0;

endpackage

// File: rtl/rr_capture_buffer_if.sv
// ---------------------------------------------------------------------------
// rr_capture_buffer_if
// Bundles the write sources, the read port and the status flags of the
// capture buffer.
//   master : producers/consumer side (drives wr_*, fix_*, rd_en)
//   slave  : the buffer itself (drives rd_*, full, empty, count,
//            next_src, overflow)
// ---------------------------------------------------------------------------
interface rr_capture_buffer_if #(
    parameter int WIDTH = 16,
    parameter int NSRC  = 2,
    parameter int DEPTH = 4
);
    import rr_capture_buffer_pkg::*;

    localparam int SRC_W = clog2(NSRC);
    localparam int CNT_W = clog2(DEPTH + 1);

    logic                  wr_en;
    logic [NSRC*WIDTH-1:0] wr_data;
    logic                  fix_mode;
    logic [SRC_W-1:0]      fix_src;
    logic                  rd_en;
    logic [WIDTH-1:0]      rd_data;
    logic [SRC_W-1:0]      rd_src;
    logic                  rd_valid;
    logic                  full;
    logic                  empty;
    logic [CNT_W-1:0]      count;
    logic [SRC_W-1:0]      next_src;
    logic                  overflow;

    modport master (
        output wr_en, wr_data, fix_mode, fix_src, rd_en,
        input  rd_data, rd_src, rd_valid, full, empty, count, next_src, overflow
    );

    modport slave (
        input  wr_en, wr_data, fix_mode, fix_src, rd_en,
        output rd_data, rd_src, rd_valid, full, empty, count, next_src, overflow
    );

endinterface

// File: rtl/rr_capture_buffer_mod_counter.sv
// ---------------------------------------------------------------------------
// mod_counter
// Wrapping counter 0 .. MOD-1; MOD need not be a power of two.
//   clk   : clock, rising edge
//   rst   : asynchronous active-high clear
//   inc   : advance by one this cycle
//   value : current count
// ---------------------------------------------------------------------------
module mod_counter
    import rr_capture_buffer_pkg::*;
#(
    parameter int MOD = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   inc,
    output logic [clog2(MOD)-1:0]  value
);

    localparam int W      = clog2(MOD);
    localparam int LAST_I = MOD - 1;
    localparam logic [W-1:0] LAST = LAST_I[W-1:0];

    // Explicit wrap at MOD-1 rather than relying on natural overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value <= '0;
        end else if (inc) begin
            value <= (value == LAST) ? '0 : value + 1'b1;
        end
    end

endmodule

// File: rtl/rr_capture_buffer.sv
// ---------------------------------------------------------------------------
// rr_capture_buffer
// Captures one word per accepted write from one of NSRC sources (round-robin
// or fixed selection), buffers DEPTH entries oldest-first and returns them
// through a registered read port tagged with the source index.
//   clk : clock, rising edge
//   rst : asynchronous active-high reset
//   bus : rr_capture_buffer_if.slave
//         in : wr_en, wr_data, fix_mode, fix_src, rd_en
//         out: rd_data, rd_src, rd_valid, full, empty, count, next_src,
//              overflow
// ---------------------------------------------------------------------------
module rr_capture_buffer
    import rr_capture_buffer_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int NSRC  = 2,
    parameter int DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    rr_capture_buffer_if.slave   bus
);

    localparam int SRC_W   = clog2(NSRC);
    localparam int CNT_W   = clog2(DEPTH + 1);
    localparam int PTR_W   = clog2(DEPTH);
    localparam int ENTRY_W = WIDTH + SRC_W;

    localparam logic [SRC_W:0]   NSRC_EXT   = NSRC[SRC_W:0];
    localparam logic [CNT_W-1:0] DEPTH_CNT  = DEPTH[CNT_W-1:0];

    logic [SRC_W-1:0]   rr_ptr;
    logic [SRC_W-1:0]   fix_clamped;
    logic [SRC_W-1:0]   sel;
    logic [WIDTH-1:0]   picked;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count_q;
    logic               overflow_q;
    logic               rd_valid_q;
    logic [WIDTH-1:0]   rd_data_q;
    logic [SRC_W-1:0]   rd_src_q;
    logic [ENTRY_W-1:0] mem [DEPTH];

    logic full_w;
    logic empty_w;
    logic wr_accept;
    logic rd_accept;
    logic drop;

    assign full_w  = (count_q == DEPTH_CNT);
    assign empty_w = (count_q == '0);

    // A write into a full buffer is still taken when a pop frees the oldest
    // slot on the same edge. A pop on an empty buffer is never taken, so a
    // simultaneous write/pop on empty has no fall-through.
    assign wr_accept = bus.wr_en && (!full_w || bus.rd_en);
    assign rd_accept = bus.rd_en && !empty_w;
    assign drop      = bus.wr_en && full_w && !bus.rd_en;

    // Out-of-range fixed selections fall back to source 0.
    always_comb begin
        fix_clamped = ({1'b0, bus.fix_src} < NSRC_EXT) ? bus.fix_src : '0;
        sel         = bus.fix_mode ? fix_clamped : rr_ptr;
    end

    // Constant-index mux keeps every slice in range even when NSRC is not
    // a power of two.
    always_comb begin
        picked = '0;
        for (int k = 0; k < NSRC; k++) begin
            if (sel == k[SRC_W-1:0]) begin
                picked = `RR_CAPTURE_BUFFER_SLICE(bus.wr_data, k, WIDTH);
            end
        end
    end

    // The round-robin pointer only moves for writes it actually chose, so
    // fixed-mode traffic leaves it parked where round-robin left off.
    mod_counter #(.MOD(NSRC)) u_rr_ptr (
        .clk   (clk),
        .rst   (rst),
        .inc   (wr_accept && !bus.fix_mode),
        .value (rr_ptr)
    );

    mod_counter #(.MOD(DEPTH)) u_wr_ptr (
        .clk   (clk),
        .rst   (rst),
        .inc   (wr_accept),
        .value (wr_ptr)
    );

    mod_counter #(.MOD(DEPTH)) u_rd_ptr (
        .clk   (clk),
        .rst   (rst),
        .inc   (rd_accept),
        .value (rd_ptr)
    );

    // Storage has no reset; contents are only ever read after being written.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wr_ptr] <= {sel, picked};
        end
    end

    // Occupancy, sticky overflow and the registered read port. When full
    // with a simultaneous write, the read samples the old entry at rd_ptr
    // before the write lands in the same slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q    <= '0;
            overflow_q <= RESET_OVERFLOW;
            rd_valid_q <= RESET_RD_VALID;
            rd_data_q  <= '0;
            rd_src_q   <= '0;
        end else begin
            if (wr_accept && !rd_accept) begin
                count_q <= count_q + 1'b1;
            end else if (rd_accept && !wr_accept) begin
                count_q <= count_q - 1'b1;
            end
            if (drop) begin
                overflow_q <= 1'b1;
            end
            rd_valid_q <= rd_accept;
            if (rd_accept) begin
                {rd_src_q, rd_data_q} <= mem[rd_ptr];
            end
        end
    end

    assign bus.rd_data  = rd_data_q;
    assign bus.rd_src   = rd_src_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.full     = full_w;
    assign bus.empty    = empty_w;
    assign bus.count    = count_q;
    assign bus.next_src = sel;
    assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_rr_capture_buffer.sv
// ---------------------------------------------------------------------------
// tb_rr_capture_buffer
// Directed scoreboard bench for rr_capture_buffer with NSRC=3, DEPTH=4,
// WIDTH=16. Sources: src0=AAAA, src1=5555, src2=1234.
// ---------------------------------------------------------------------------
module tb_rr_capture_buffer;

    localparam int WIDTH = 16;
    localparam int NSRC  = 3;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [15:0] data;
        logic [1:0]  src;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    exp_t sb [$];

    rr_capture_buffer_if #(.WIDTH(WIDTH), .NSRC(NSRC), .DEPTH(DEPTH)) bus ();

    rr_capture_buffer #(.WIDTH(WIDTH), .NSRC(NSRC), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Drives one cycle of stimulus from a falling edge; when a pop is meant
    // to be accepted, its expected word is queued for the monitor.
    task automatic applyStimulus(input logic wr, input logic rd, input logic fm,
                                 input logic [1:0] fs, input logic push,
                                 input logic [15:0] d, input logic [1:0] s);
        exp_t e;
        bus.wr_en    = wr;
        bus.rd_en    = rd;
        bus.fix_mode = fm;
        bus.fix_src  = fs;
        if (push) begin
            e.data = d;
            e.src  = s;
            sb.push_back(e);
        end
        @(negedge clk);
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
    endtask

    task automatic writeRr();
        applyStimulus(1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 16'h0, 2'd0);
    endtask

    task automatic writeFix(input logic [1:0] fs);
        applyStimulus(1'b1, 1'b0, 1'b1, fs, 1'b0, 16'h0, 2'd0);
    endtask

    task automatic popExpect(input logic [15:0] d, input logic [1:0] s);
        applyStimulus(1'b0, 1'b1, bus.fix_mode, bus.fix_src, 1'b1, d, s);
    endtask

    // Monitor: every rd_valid pulse consumes exactly one scoreboard entry.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (!rst && bus.rd_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpected_rd_valid: got data %0h src %0d expected no pop",
                             bus.rd_data, bus.rd_src);
                end else begin
                    e = sb.pop_front();
                    checkOutput("pop_data", 32'(bus.rd_data), 32'(e.data));
                    checkOutput("pop_src", 32'(bus.rd_src), 32'(e.src));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        checks       = 0;
        failures     = 0;
        rst          = 1'b1;
        bus.wr_en    = 1'b0;
        bus.rd_en    = 1'b0;
        bus.fix_mode = 1'b0;
        bus.fix_src  = 2'd0;
        bus.wr_data  = {16'h1234, 16'h5555, 16'hAAAA};
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] reset state");
        checkOutput("rst_count", 32'(bus.count), 32'd0);
        checkOutput("rst_empty", 32'(bus.empty), 32'd1);
        checkOutput("rst_full", 32'(bus.full), 32'd0);
        checkOutput("rst_overflow", 32'(bus.overflow), 32'd0);
        checkOutput("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
        checkOutput("rst_rd_data", 32'(bus.rd_data), 32'd0);
        checkOutput("rst_rd_src", 32'(bus.rd_src), 32'd0);
        checkOutput("rst_next_src", 32'(bus.next_src), 32'd0);

        $display("[TB] fill in round-robin");
        repeat (4) writeRr();
        checkOutput("fill_count", 32'(bus.count), 32'd4);
        checkOutput("fill_full", 32'(bus.full), 32'd1);
        checkOutput("fill_empty", 32'(bus.empty), 32'd0);
        checkOutput("fill_next_src", 32'(bus.next_src), 32'd1);

        $display("[TB] dropped write and full write+pop");
        writeRr();
        checkOutput("drop_overflow", 32'(bus.overflow), 32'd1);
        checkOutput("drop_count", 32'(bus.count), 32'd4);
        checkOutput("drop_next_src", 32'(bus.next_src), 32'd1);
        applyStimulus(1'b1, 1'b1, 1'b0, 2'd0, 1'b1, 16'hAAAA, 2'd0);
        checkOutput("wrrd_full_count", 32'(bus.count), 32'd4);
        checkOutput("wrrd_full_full", 32'(bus.full), 32'd1);
        checkOutput("wrrd_next_src", 32'(bus.next_src), 32'd2);
        popExpect(16'h5555, 2'd1);
        popExpect(16'h1234, 2'd2);
        popExpect(16'hAAAA, 2'd0);
        popExpect(16'h5555, 2'd1);
        checkOutput("drain_count", 32'(bus.count), 32'd0);
        checkOutput("drain_empty", 32'(bus.empty), 32'd1);

        $display("[TB] asynchronous reset with entries held");
        repeat (4) writeRr();
        writeRr();
        checkOutput("overflow_sticky", 32'(bus.overflow), 32'd1);
        popExpect(16'h1234, 2'd2);
        checkOutput("prerst_count", 32'(bus.count), 32'd3);
        checkOutput("prerst_rd_valid", 32'(bus.rd_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("arst_count", 32'(bus.count), 32'd0);
        checkOutput("arst_empty", 32'(bus.empty), 32'd1);
        checkOutput("arst_overflow", 32'(bus.overflow), 32'd0);
        checkOutput("arst_rd_valid", 32'(bus.rd_valid), 32'd0);
        checkOutput("arst_rd_data", 32'(bus.rd_data), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        checkOutput("postrst_next_src", 32'(bus.next_src), 32'd0);

        $display("[TB] round-robin wrap at NSRC=3");
        repeat (4) writeRr();
        applyStimulus(1'b1, 1'b1, 1'b0, 2'd0, 1'b1, 16'hAAAA, 2'd0);
        applyStimulus(1'b1, 1'b1, 1'b0, 2'd0, 1'b1, 16'h5555, 2'd1);
        applyStimulus(1'b1, 1'b1, 1'b0, 2'd0, 1'b1, 16'h1234, 2'd2);
        checkOutput("wrap_count", 32'(bus.count), 32'd4);
        checkOutput("wrap_next_src", 32'(bus.next_src), 32'd1);
        popExpect(16'hAAAA, 2'd0);
        popExpect(16'h5555, 2'd1);
        popExpect(16'h1234, 2'd2);
        popExpect(16'hAAAA, 2'd0);

        $display("[TB] fixed selection and round-robin resume");
        writeFix(2'd1);
        writeFix(2'd1);
        bus.fix_mode = 1'b0;
        #1;
        checkOutput("resume_next_src", 32'(bus.next_src), 32'd1);
        writeRr();
        writeRr();
        popExpect(16'h5555, 2'd1);
        popExpect(16'h5555, 2'd1);
        popExpect(16'h5555, 2'd1);
        popExpect(16'h1234, 2'd2);
        bus.fix_mode = 1'b1;
        bus.fix_src  = 2'd3;
        #1;
        checkOutput("clamp_next_src", 32'(bus.next_src), 32'd0);
        writeFix(2'd3);
        writeFix(2'd2);
        popExpect(16'hAAAA, 2'd0);
        popExpect(16'h1234, 2'd2);
        bus.fix_mode = 1'b0;
        #1;
        checkOutput("held_rr_next_src", 32'(bus.next_src), 32'd0);

        $display("[TB] empty-buffer corner cases");
        applyStimulus(1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 16'h0, 2'd0);
        checkOutput("empty_pop_rd_valid", 32'(bus.rd_valid), 32'd0);
        checkOutput("empty_pop_rd_data", 32'(bus.rd_data), 32'h1234);
        checkOutput("empty_pop_rd_src", 32'(bus.rd_src), 32'd2);
        checkOutput("empty_pop_count", 32'(bus.count), 32'd0);
        applyStimulus(1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 16'h0, 2'd0);
        checkOutput("empty_wrrd_count", 32'(bus.count), 32'd1);
        checkOutput("empty_wrrd_rd_valid", 32'(bus.rd_valid), 32'd0);
        checkOutput("empty_wrrd_rd_data", 32'(bus.rd_data), 32'h1234);
        popExpect(16'hAAAA, 2'd0);
        checkOutput("final_empty", 32'(bus.empty), 32'd1);

        @(negedge clk);
        checkOutput("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
